// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit that sits beside the EX-stage ALU.
// Multiplies use shift-add and divides use restoring division. Both work on operand
// magnitudes and retire UNROLL bits per CALC cycle. The sign is fixed up when the
// result is formed.
// Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and
// multiply-by-zero skip CALC and report done one cycle after accept.
module ex_muldiv_unit #(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            stall
);

   localparam int ITER = XLEN / UNROLL;
   localparam int CW   = $clog2(ITER + 1);
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state_q, state_d;

   logic [2:0]      op_q;
   logic            neg_q, rem_neg_q, div_zero_q;
   logic [XLEN-1:0] hi_q, lo_q, opnd_q;
   logic [XLEN-1:0] hi_n, lo_n;
   logic [CW-1:0]   cnt_q;
   logic [XLEN-1:0] result_q;

   logic            is_div, a_signed, b_signed, sa, sb;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero_in;
   logic            early;
   logic [XLEN-1:0] early_res, calc_res;

   // Operand decode: for divides, op[0] marks the unsigned variants.
   // For multiplies, only MULHU treats rs1 as unsigned, and MULHSU/MULHU treat rs2 as unsigned.
   assign is_div      = op[2];
   assign a_signed    = is_div ? ~op[0] : (op[1:0] != 2'b11);
   assign b_signed    = is_div ? ~op[0] : ~op[1];
   assign sa          = a_signed & rs1[XLEN-1];
   assign sb          = b_signed & rs2[XLEN-1];
   assign a_mag       = sa ? -rs1 : rs1;
   assign b_mag       = sb ? -rs2 : rs2;
   assign div_zero_in = is_div & (rs2 == '0);

`ifdef MULDIV_EARLY_OUT_EN
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
   logic ovf_in;
   assign ovf_in = is_div & ~op[0] & (rs1 == MIN_VAL) & (rs2 == '1);
   assign early  = div_zero_in | ovf_in | (~is_div & ((rs1 == '0) | (rs2 == '0)));

   // Closed-form results for the cases that bypass the iterative datapath.
   always_comb begin
      early_res = '0;
      if (div_zero_in) begin
         early_res = op[1] ? rs1 : '1;
      end else if (ovf_in) begin
         early_res = op[1] ? '0 : MIN_VAL;
      end
   end
`else
   assign early     = 1'b0;
   assign early_res = '0;
`endif

   // UNROLL iterations of either shift-add multiply or restoring divide.
   // The multiply product shifts right through {hi,lo}. The divide quotient shifts into lo from the right.
   always_comb begin
      logic [XLEN:0] rem_t;
      logic [XLEN:0] sum_t;
      hi_n  = hi_q;
      lo_n  = lo_q;
      rem_t = '0;
      sum_t = '0;
      for (int i = 0; i < UNROLL; i++) begin
         if (op_q[2]) begin
            rem_t = {hi_n, lo_n[XLEN-1]};
            lo_n  = {lo_n[XLEN-2:0], 1'b0};
            if (rem_t >= {1'b0, opnd_q}) begin
               rem_t   = rem_t - {1'b0, opnd_q};
               lo_n[0] = 1'b1;
            end
            hi_n = rem_t[XLEN-1:0];
         end else begin
            sum_t = lo_n[0] ? ({1'b0, hi_n} + {1'b0, opnd_q}) : {1'b0, hi_n};
            lo_n  = {sum_t[0], lo_n[XLEN-1:1]};
            hi_n  = sum_t[XLEN:1];
         end
      end
   end

   // Final sign fix-up and result selection from the last iteration's values.
   always_comb begin
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   quot, remd;
      prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
      quot = div_zero_q ? '1 : (neg_q ? -lo_n : lo_n);
      remd = rem_neg_q ? -hi_n : hi_n;
      if (op_q[2]) begin
         calc_res = op_q[1] ? remd : quot;
      end else begin
         calc_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end
   end

   // Next-state logic. A flush always returns the unit to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = early ? DONE : CALC;
         CALC:    if (cnt_q == LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Operand latch on accept, iteration in CALC, and result capture on the last step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q       <= '0;
         neg_q      <= 1'b0;
         rem_neg_q  <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         opnd_q     <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
      end else if (flush) begin
         cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_q       <= op;
                  neg_q      <= sa ^ sb;
                  rem_neg_q  <= sa;
                  div_zero_q <= div_zero_in;
                  hi_q       <= '0;
                  lo_q       <= is_div ? a_mag : b_mag;
                  opnd_q     <= is_div ? b_mag : a_mag;
                  cnt_q      <= '0;
                  if (early) result_q <= early_res;
               end
            end
            CALC: begin
               hi_q  <= hi_n;
               lo_q  <= lo_n;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LAST) result_q <= calc_res;
            end
            default: ;
         endcase
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign stall  = start & ~done;

endmodule
